sal_bank_ctrl: RTL and testbench

// Per-bank DDR2 command sequencer; one instance per bank, directly upstream of the command scheduler.

---
 rtl/sal_bank_pkg.sv | 11 +
 rtl/sal_bk_timer.sv | 19 +
 rtl/sal_bank_ctrl.sv | 78 +++++++
 tb/tb_sal_bank_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sal_bank_pkg.sv
// sal_bank_pkg: bank FSM state type, timer width and default DDR2 per-bank timings
package sal_bank_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, REFRESH} bank_state_t;
  localparam int TIMER_W = 8;
  localparam int T_RCD_D = 3;
  localparam int T_RAS_D = 8;
  localparam int T_RP_D  = 3;
  localparam int T_RTP_D = 2;
  localparam int T_WTP_D = 9;
  localparam int T_RFC_D = 26;
endpackage

// File: rtl/sal_bk_timer.sv
// sal_bk_timer: loadable down-counter that holds at zero and flags when expired
module sal_bk_timer
  import sal_bank_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/sal_bank_ctrl.sv
// sal_bank_ctrl: per-bank DDR2 command sequencer with open-page policy and per-bank timing
module sal_bank_ctrl
  import sal_bank_pkg::*;
#(
  parameter int ROW_AW = 14,
  parameter int COL_AW = 10,
  parameter int T_RCD  = T_RCD_D,
  parameter int T_RAS  = T_RAS_D,
  parameter int T_RP   = T_RP_D,
  parameter int T_RTP  = T_RTP_D,
  parameter int T_WTP  = T_WTP_D,
  parameter int T_RFC  = T_RFC_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ROW_AW-1:0] req_row,
  input  logic [COL_AW-1:0] req_col,
  output logic              req_ready,
  input  logic              ref_pending,
  output logic              ref_done,
  output logic              act_req,
  input  logic              act_gnt,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic              wr_req,
  input  logic              wr_gnt,
  output logic              pre_req,
  input  logic              pre_gnt,
  output logic              ref_req,
  input  logic              ref_gnt,
  output logic [ROW_AW-1:0] cmd_row,
  output logic [COL_AW-1:0] cmd_col,
  output logic              bank_open,
  output logic [ROW_AW-1:0] open_row
);
  bank_state_t state, state_nx;
  logic rcd_z, ras_z, rp_z, rtp_z, wtp_z, rfc_z;
  logic act_take, rd_take, wr_take, pre_take, ref_take, need_pre;
  // A pending refresh or a row miss both force the open row closed first
  assign need_pre = ref_pending || (req_valid && req_row != open_row);
  assign ref_req  = state == IDLE && ref_pending && rp_z;
  assign act_req  = state == IDLE && !ref_pending && req_valid && rp_z;
  assign pre_req  = state == ACTIVE && need_pre && ras_z && rtp_z && wtp_z;
  assign rd_req   = state == ACTIVE && !need_pre && req_valid && rcd_z && !req_wr;
  assign wr_req   = state == ACTIVE && !need_pre && req_valid && rcd_z && req_wr;
  assign ref_done = state == REFRESH && rfc_z;
  assign act_take = act_req && act_gnt;
  assign rd_take  = rd_req && rd_gnt;
  assign wr_take  = wr_req && wr_gnt;
  assign pre_take = pre_req && pre_gnt;
  assign ref_take = ref_req && ref_gnt;
  assign req_ready = rd_take || wr_take;
  assign bank_open = state == ACTIVE;
  assign cmd_row   = req_row;
  assign cmd_col   = req_col;
  always_comb
    state_nx = ref_take ? REFRESH :
               act_take ? ACTIVE  :
               (pre_take || ref_done) ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      open_row <= '0;
    end else begin
      state <= state_nx;
      if (act_take) open_row <= req_row;
    end
  sal_bk_timer u_rcd (.clk, .rst, .load(act_take), .load_val(TIMER_W'(T_RCD - 1)), .zero(rcd_z));
  sal_bk_timer u_ras (.clk, .rst, .load(act_take), .load_val(TIMER_W'(T_RAS - 1)), .zero(ras_z));
  sal_bk_timer u_rp  (.clk, .rst, .load(pre_take), .load_val(TIMER_W'(T_RP - 1)),  .zero(rp_z));
  sal_bk_timer u_rtp (.clk, .rst, .load(rd_take),  .load_val(TIMER_W'(T_RTP - 1)), .zero(rtp_z));
  sal_bk_timer u_wtp (.clk, .rst, .load(wr_take),  .load_val(TIMER_W'(T_WTP - 1)), .zero(wtp_z));
  sal_bk_timer u_rfc (.clk, .rst, .load(ref_take), .load_val(TIMER_W'(T_RFC - 1)), .zero(rfc_z));
  a_one_req: assert property (@(posedge clk) disable iff (rst)
    $onehot0({act_req, rd_req, wr_req, pre_req, ref_req}));
endmodule

// File: tb/tb_sal_bank_ctrl.sv
// tb_sal_bank_ctrl: random traffic against a timestamp-based bank model with a transaction scoreboard
module tb_sal_bank_ctrl;
  localparam int ROW_AW = 14, COL_AW = 10;
  localparam int T_RCD = 3, T_RAS = 8, T_RP = 3, T_RTP = 2, T_WTP = 9, T_RFC = 26;
  typedef struct packed {
    logic              wr;
    logic [ROW_AW-1:0] row;
    logic [COL_AW-1:0] col;
  } txn_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wr = 0, ref_pending = 0;
  logic [ROW_AW-1:0] req_row = '0;
  logic [COL_AW-1:0] req_col = '0;
  logic act_gnt = 0, rd_gnt = 0, wr_gnt = 0, pre_gnt = 0, ref_gnt = 0;
  logic req_ready, ref_done, act_req, rd_req, wr_req, pre_req, ref_req, bank_open;
  logic [ROW_AW-1:0] cmd_row, open_row;
  logic [COL_AW-1:0] cmd_col;
  int checks = 0, errors = 0;
  txn_t sb[$];
  sal_bank_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_row(req_row),
    .req_col(req_col), .req_ready(req_ready), .ref_pending(ref_pending), .ref_done(ref_done),
    .act_req(act_req), .act_gnt(act_gnt), .rd_req(rd_req), .rd_gnt(rd_gnt),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .pre_req(pre_req), .pre_gnt(pre_gnt),
    .ref_req(ref_req), .ref_gnt(ref_gnt), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .bank_open(bank_open), .open_row(open_row)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  // Reference model: bank status plus the cycle of the most recent grant of each command
  int cyc = 0, last_act, last_rd, last_wr, last_pre, last_ref;
  bit m_open, m_in_ref;
  logic [ROW_AW-1:0] m_row;
  logic e_act, e_rd, e_wr, e_pre, e_ref, e_done, e_ready;
  txn_t t;
  function automatic void model_reset();
    last_act = -1000; last_rd = -1000; last_wr = -1000; last_pre = -1000; last_ref = -1000;
    m_open = 0; m_in_ref = 0; m_row = '0;
  endfunction
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        model_reset();
        sb.delete();
        check("reset_outs", {act_req, rd_req, wr_req, pre_req, ref_req, ref_done, req_ready,
                             bank_open, open_row}, '0);
      end else begin
        {e_act, e_rd, e_wr, e_pre, e_ref, e_done} = '0;
        if (m_in_ref) e_done = cyc >= last_ref + T_RFC;
        else if (!m_open) begin
          if (cyc >= last_pre + T_RP) begin
            e_ref = ref_pending;
            e_act = !ref_pending && req_valid;
          end
        end else if (ref_pending || (req_valid && req_row != m_row))
          e_pre = cyc >= last_act + T_RAS && cyc >= last_rd + T_RTP && cyc >= last_wr + T_WTP;
        else if (req_valid && cyc >= last_act + T_RCD) begin
          e_rd = !req_wr;
          e_wr = req_wr;
        end
        e_ready = (e_rd && rd_gnt) || (e_wr && wr_gnt);
        check("cmd_vec", {act_req, rd_req, wr_req, pre_req, ref_req, ref_done, req_ready, bank_open},
              {e_act, e_rd, e_wr, e_pre, e_ref, e_done, e_ready, m_open});
        if (m_open) check("open_row", open_row, m_row);
        if (e_act) check("cmd_row", cmd_row, req_row);
        if (req_ready) begin
          if (sb.size() == 0) check("sb_empty", 1, 0);
          else begin
            t = sb.pop_front();
            check("sb_txn", {wr_req, cmd_row, cmd_col}, {t.wr, t.row, t.col});
          end
        end
        if (e_act && act_gnt) begin m_open = 1; m_row = req_row; last_act = cyc; end
        if (e_rd && rd_gnt) last_rd = cyc;
        if (e_wr && wr_gnt) last_wr = cyc;
        if (e_pre && pre_gnt) begin m_open = 0; last_pre = cyc; end
        if (e_ref && ref_gnt) begin m_in_ref = 1; last_ref = cyc; end
        if (e_done) m_in_ref = 0;
      end
    end
  end
  // Stimulus: upstream holds each request until req_ready, refresh held until ref_done
  int grant_pct = 100;
  bit allow_new = 1, allow_ref = 1, seen_ready, seen_done;
  task automatic step();
    int r;
    @(negedge clk);
    seen_ready = req_ready;
    seen_done = ref_done;
    @(posedge clk);
    #1;
    if (seen_done) ref_pending = 0;
    else if (!ref_pending && allow_ref && $urandom_range(0, 99) < 3) ref_pending = 1;
    if (req_valid && seen_ready) req_valid = 0;
    if (!req_valid && allow_new && $urandom_range(0, 99) < 60) begin
      r = $urandom_range(0, 2);
      req_valid = 1;
      req_wr = 1'($urandom_range(0, 1));
      req_row = ROW_AW'(r == 0 ? 5 : (r == 1 ? 9 : 2));
      req_col = COL_AW'($urandom_range(0, 1023));
      sb.push_back('{wr: req_wr, row: req_row, col: req_col});
    end
    act_gnt = $urandom_range(0, 99) < grant_pct;
    rd_gnt  = $urandom_range(0, 99) < grant_pct;
    wr_gnt  = $urandom_range(0, 99) < grant_pct;
    pre_gnt = $urandom_range(0, 99) < grant_pct;
    ref_gnt = $urandom_range(0, 99) < grant_pct;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int p = 0; p < 3; p++) begin
      grant_pct = p == 0 ? 100 : (p == 1 ? 70 : 15);
      repeat (600) step();
    end
    grant_pct = 100;
    allow_new = 0;
    allow_ref = 0;
    for (int i = 0; i < 400 && (req_valid || ref_pending); i++) step();
    checks++;
    if (req_valid || ref_pending) begin
      errors++;
      $display("FAIL drain_timeout: req_valid=%0b ref_pending=%0b still high", req_valid, ref_pending);
    end
    ref_pending = 1;
    for (int i = 0; i < 60 && !m_in_ref; i++) step();
    checks++;
    if (!m_in_ref) begin
      errors++;
      $display("FAIL refresh_entry_timeout: ref_req/ref_gnt never completed, got 0 expected 1");
    end
    repeat (5) step();
    #2 rst = 1;
    ref_pending = 0;
    #1 check("async_rst", {act_req, rd_req, wr_req, pre_req, ref_req, ref_done, req_ready,
                           bank_open, open_row}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    allow_new = 1;
    allow_ref = 1;
    repeat (40) step();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
